sequenciador_batalha_naval: RTL and testbench

// Clocked game sequencer for the 5x7 battleship board (5 columns, 7 rows, active-low cells, 0 = ship/lit).

---
 rtl/sequenciador_batalha_naval_if.sv | 46 ++++
 rtl/sequenciador_batalha_naval.sv | 181 ++++++++++++++++++
 tb/tb_sequenciador_batalha_naval.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sequenciador_batalha_naval_if.sv
// rtl/sequenciador_batalha_naval_if.sv - board/game signal bundle for the battleship sequencer
// Purpose: groups the switches, buttons, column display and RGB LED signals.
// Ports (slave = sequencer view):
//   ligado_i, modo_i, salvar_jogo_i, confirmar_ataque_i  control levels
//   ataque_colunas_i, ataque_linhas_i                     attack target (1..5, 1..7)
//   colunaK_posicionamento_i                              fleet switches, bit r-1 = row r, 0 = ship
//   colunaK_saida_o, ledRGB_o, tentativas_restantes_o, fim_jogo_o  display and status
interface sequenciador_batalha_naval_if;
  logic       ligado_i;
  logic       modo_i;
  logic       salvar_jogo_i;
  logic       confirmar_ataque_i;
  logic [2:0] ataque_colunas_i;
  logic [2:0] ataque_linhas_i;
  logic [6:0] coluna1_posicionamento_i;
  logic [6:0] coluna2_posicionamento_i;
  logic [6:0] coluna3_posicionamento_i;
  logic [6:0] coluna4_posicionamento_i;
  logic [6:0] coluna5_posicionamento_i;
  logic [6:0] coluna1_saida_o;
  logic [6:0] coluna2_saida_o;
  logic [6:0] coluna3_saida_o;
  logic [6:0] coluna4_saida_o;
  logic [6:0] coluna5_saida_o;
  logic [1:0] ledRGB_o;
  logic [5:0] tentativas_restantes_o;
  logic       fim_jogo_o;

  modport master (
    output ligado_i, modo_i, salvar_jogo_i, confirmar_ataque_i,
    output ataque_colunas_i, ataque_linhas_i,
    output coluna1_posicionamento_i, coluna2_posicionamento_i, coluna3_posicionamento_i,
    output coluna4_posicionamento_i, coluna5_posicionamento_i,
    input  coluna1_saida_o, coluna2_saida_o, coluna3_saida_o, coluna4_saida_o, coluna5_saida_o,
    input  ledRGB_o, tentativas_restantes_o, fim_jogo_o
  );

  modport slave (
    input  ligado_i, modo_i, salvar_jogo_i, confirmar_ataque_i,
    input  ataque_colunas_i, ataque_linhas_i,
    input  coluna1_posicionamento_i, coluna2_posicionamento_i, coluna3_posicionamento_i,
    input  coluna4_posicionamento_i, coluna5_posicionamento_i,
    output coluna1_saida_o, coluna2_saida_o, coluna3_saida_o, coluna4_saida_o, coluna5_saida_o,
    output ledRGB_o, tentativas_restantes_o, fim_jogo_o
  );
endinterface

// File: rtl/sequenciador_batalha_naval.sv
// rtl/sequenciador_batalha_naval.sv - 5x7 battleship game sequencer
// Purpose: latches the fleet, sequences attacks, keeps hit/attacked maps, counts hits and
//   attempts, holds the hit/miss LED for TEMPO_LED cycles and declares victory or defeat.
// Ports:
//   clk_i    system clock
//   reset_i  synchronous active-high reset
//   bus      sequenciador_batalha_naval_if.slave (switches, buttons, display, LED, status)
// Board maps are 35-bit vectors: cell (col, row) lives at bit 7*(col-1) + (row-1); 0 = ship/hit.
module sequenciador_batalha_naval #(
  parameter int MAX_TENTATIVAS = 15,
  parameter int TEMPO_LED      = 25_000_000
) (
  input logic clk_i,
  input logic reset_i,
  sequenciador_batalha_naval_if.slave bus
);
  typedef enum logic [2:0] {
    DESLIGADO, POSICIONAMENTO, ATAQUE, AVALIA, RESULTADO, VITORIA, DERROTA
  } estado_t;

  localparam logic [5:0]    TENT_MAX  = 6'(MAX_TENTATIVAS);
  localparam int            TW        = $clog2(TEMPO_LED + 1);
  localparam logic [TW-1:0] TEMPO_FIM = TW'(TEMPO_LED - 1);

  estado_t       estado_q;
  logic [34:0]   tabuleiro_q;     // saved fleet
  logic [34:0]   mapa_acertos_q;  // 0 = cell hit
  logic [34:0]   atacado_q;       // 0 = cell already attacked
  logic [34:0]   saida_q;
  logic          jogo_salvo_q;
  logic [5:0]    acertos_q, total_navios_q, tentativas_q;
  logic [TW-1:0] timer_q;
  logic [2:0]    col_q, lin_q;
  logic          salvar_q, salvar_ant_q, conf_q, conf_ant_q;
  logic [1:0]    led_q;
  logic          fim_q;

  logic [34:0] posic;
  logic [5:0]  zeros_posic;
  logic        salvar_sobe, conf_sobe;
  logic        coord_ok, celula_livre, acerto;
  logic [5:0]  idx;
  logic [34:0] mascara;

  assign posic = {bus.coluna5_posicionamento_i, bus.coluna4_posicionamento_i,
                  bus.coluna3_posicionamento_i, bus.coluna2_posicionamento_i,
                  bus.coluna1_posicionamento_i};

  // Button edges are taken between two registered copies, so an attack lands two cycles
  // after the first edge that samples the button high.
  assign salvar_sobe = salvar_q & ~salvar_ant_q;
  assign conf_sobe   = conf_q & ~conf_ant_q;

  always_comb begin
    zeros_posic = '0;
    for (int i = 0; i < 35; i++) zeros_posic = zeros_posic + {5'd0, ~posic[i]};
  end

  always_comb begin
    coord_ok     = (col_q >= 3'd1) && (col_q <= 3'd5) && (lin_q >= 3'd1) && (lin_q <= 3'd7);
    idx          = ({3'd0, col_q} - 6'd1) * 6'd7 + {3'd0, lin_q} - 6'd1;
    mascara      = coord_ok ? (35'd1 << idx) : '0;
    celula_livre = coord_ok && ((atacado_q & mascara) != '0);
    acerto       = (tabuleiro_q & mascara) == '0;
  end

  always_ff @(posedge clk_i) begin
    salvar_q     <= bus.salvar_jogo_i;
    salvar_ant_q <= salvar_q;
    conf_q       <= bus.confirmar_ataque_i;
    conf_ant_q   <= conf_q;
    if (reset_i || !bus.ligado_i) begin
      estado_q       <= DESLIGADO;
      saida_q        <= '1;
      led_q          <= 2'b00;
      fim_q          <= 1'b0;
      tentativas_q   <= TENT_MAX;
      tabuleiro_q    <= '1;
      mapa_acertos_q <= '1;
      atacado_q      <= '1;
      jogo_salvo_q   <= 1'b0;
      acertos_q      <= '0;
      total_navios_q <= '0;
      timer_q        <= '0;
      col_q          <= '0;
      lin_q          <= '0;
    end else begin
      case (estado_q)
        DESLIGADO: estado_q <= bus.modo_i ? ATAQUE : POSICIONAMENTO;
        POSICIONAMENTO: begin
          saida_q <= posic;
          led_q   <= 2'b00;
          // An empty board is not a game: the save is dropped and the old fleet kept.
          if (salvar_sobe && zeros_posic != '0) begin
            tabuleiro_q    <= posic;
            total_navios_q <= zeros_posic;
            jogo_salvo_q   <= 1'b1;
          end
          if (bus.modo_i) estado_q <= ATAQUE;
        end
        default: begin
          if (!bus.modo_i) begin
            // Leaving attack mode abandons the game in progress, even mid-hold.
            estado_q       <= POSICIONAMENTO;
            saida_q        <= posic;
            led_q          <= 2'b00;
            fim_q          <= 1'b0;
            mapa_acertos_q <= '1;
            atacado_q      <= '1;
            acertos_q      <= '0;
            jogo_salvo_q   <= 1'b0;
            tentativas_q   <= TENT_MAX;
          end else begin
            case (estado_q)
              ATAQUE: begin
                saida_q <= jogo_salvo_q ? mapa_acertos_q : '1;
                led_q   <= 2'b00;
                if (conf_sobe && jogo_salvo_q) begin
                  col_q    <= bus.ataque_colunas_i;
                  lin_q    <= bus.ataque_linhas_i;
                  estado_q <= AVALIA;
                end
              end
              AVALIA: begin
                estado_q <= RESULTADO;
                timer_q  <= TEMPO_FIM;
                if (!celula_livre) begin
                  led_q <= 2'b11;
                end else begin
                  atacado_q <= atacado_q & ~mascara;
                  if (tentativas_q != '0) tentativas_q <= tentativas_q - 6'd1;
                  if (acerto) begin
                    mapa_acertos_q <= mapa_acertos_q & ~mascara;
                    saida_q        <= mapa_acertos_q & ~mascara;
                    acertos_q      <= acertos_q + 6'd1;
                    led_q          <= 2'b10;
                  end else begin
                    led_q <= 2'b01;
                  end
                end
              end
              RESULTADO: begin
                if (timer_q == '0) begin
                  // Victory is tested first so a fleet sunk on the last attempt still wins.
                  if (acertos_q == total_navios_q) begin
                    estado_q <= VITORIA;
                    led_q    <= 2'b10;
                    fim_q    <= 1'b1;
                    saida_q  <= mapa_acertos_q;
                  end else if (tentativas_q == '0) begin
                    estado_q <= DERROTA;
                    led_q    <= 2'b01;
                    fim_q    <= 1'b1;
                    saida_q  <= tabuleiro_q;
                  end else begin
                    estado_q <= ATAQUE;
                    led_q    <= 2'b00;
                  end
                end else begin
                  timer_q <= timer_q - TW'(1);
                end
              end
              VITORIA: saida_q  <= mapa_acertos_q;
              DERROTA: saida_q  <= tabuleiro_q;
              default: estado_q <= DESLIGADO;
            endcase
          end
        end
      endcase
    end
  end

  assign bus.coluna1_saida_o        = saida_q[6:0];
  assign bus.coluna2_saida_o        = saida_q[13:7];
  assign bus.coluna3_saida_o        = saida_q[20:14];
  assign bus.coluna4_saida_o        = saida_q[27:21];
  assign bus.coluna5_saida_o        = saida_q[34:28];
  assign bus.ledRGB_o               = led_q;
  assign bus.tentativas_restantes_o = tentativas_q;
  assign bus.fim_jogo_o             = fim_q;
endmodule

// File: tb/tb_sequenciador_batalha_naval.sv
// tb/tb_sequenciador_batalha_naval.sv - self-checking bench for the battleship sequencer
module tb_sequenciador_batalha_naval;
  localparam int TEMPO = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sequenciador_batalha_naval_if bus ();
  sequenciador_batalha_naval_if bus2 ();

  // Second instance with two attempts shares every input with the main one.
  assign bus2.ligado_i                 = bus.ligado_i;
  assign bus2.modo_i                   = bus.modo_i;
  assign bus2.salvar_jogo_i            = bus.salvar_jogo_i;
  assign bus2.confirmar_ataque_i       = bus.confirmar_ataque_i;
  assign bus2.ataque_colunas_i         = bus.ataque_colunas_i;
  assign bus2.ataque_linhas_i          = bus.ataque_linhas_i;
  assign bus2.coluna1_posicionamento_i = bus.coluna1_posicionamento_i;
  assign bus2.coluna2_posicionamento_i = bus.coluna2_posicionamento_i;
  assign bus2.coluna3_posicionamento_i = bus.coluna3_posicionamento_i;
  assign bus2.coluna4_posicionamento_i = bus.coluna4_posicionamento_i;
  assign bus2.coluna5_posicionamento_i = bus.coluna5_posicionamento_i;

  sequenciador_batalha_naval #(.MAX_TENTATIVAS(15), .TEMPO_LED(TEMPO)) dut (
    .clk_i(clk), .reset_i(reset), .bus(bus.slave));
  sequenciador_batalha_naval #(.MAX_TENTATIVAS(2), .TEMPO_LED(TEMPO)) dut2 (
    .clk_i(clk), .reset_i(reset), .bus(bus2.slave));

  logic [34:0] saida1, saida2;
  assign saida1 = {bus.coluna5_saida_o, bus.coluna4_saida_o, bus.coluna3_saida_o,
                   bus.coluna2_saida_o, bus.coluna1_saida_o};
  assign saida2 = {bus2.coluna5_saida_o, bus2.coluna4_saida_o, bus2.coluna3_saida_o,
                   bus2.coluna2_saida_o, bus2.coluna1_saida_o};

  int vectors = 0;
  int miscompares = 0;

  // Reference model: plain arrays indexed by (column, row), both 1-based.
  bit m_ship [8][8];
  bit m_att  [8][8];
  int m_tent, m_hits, m_total;
  int ships [$];

  typedef struct {
    int         col;
    int         row;
    logic [1:0] led;
    int         tent;
    logic [1:0] led_after;
    logic       fim;
  } vec_t;

  vec_t tabela [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_clear(input int tent);
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 8; r++) begin
        m_ship[c][r] = 1'b0;
        m_att[c][r]  = 1'b0;
      end
    ships.delete();
    m_tent  = tent;
    m_hits  = 0;
    m_total = 0;
  endfunction

  function automatic void model_ship(input int c, input int r);
    if (!m_ship[c][r]) begin
      m_ship[c][r] = 1'b1;
      ships.push_back(c * 8 + r);
      m_total++;
    end
  endfunction

  function automatic logic [1:0] model_attack(input int c, input int r);
    if (c < 1 || c > 5 || r < 1 || r > 7) return 2'b11;
    if (m_att[c][r]) return 2'b11;
    m_att[c][r] = 1'b1;
    if (m_tent > 0) m_tent--;
    if (m_ship[c][r]) begin
      m_hits++;
      return 2'b10;
    end
    return 2'b01;
  endfunction

  // board_view=1: the saved fleet; board_view=0: only cells both shipped and attacked.
  function automatic logic [34:0] exp_map(input bit board_view);
    logic [34:0] m;
    m = '1;
    for (int c = 1; c <= 5; c++)
      for (int r = 1; r <= 7; r++)
        if (m_ship[c][r] && (board_view || m_att[c][r])) m[(c - 1) * 7 + r - 1] = 1'b0;
    return m;
  endfunction

  task automatic drive_board(input logic [34:0] b);
    bus.coluna1_posicionamento_i = b[6:0];
    bus.coluna2_posicionamento_i = b[13:7];
    bus.coluna3_posicionamento_i = b[20:14];
    bus.coluna4_posicionamento_i = b[27:21];
    bus.coluna5_posicionamento_i = b[34:28];
  endtask

  task automatic save_board();
    bus.salvar_jogo_i = 1'b1;
    tick();
    tick();
    bus.salvar_jogo_i = 1'b0;
    tick();
  endtask

  task automatic do_attack(input int c, input int r, output logic [1:0] led_pre,
                           output logic [1:0] led_e, output logic held, output logic [1:0] led_a);
    bus.ataque_colunas_i   = 3'(c);
    bus.ataque_linhas_i    = 3'(r);
    bus.confirmar_ataque_i = 1'b1;
    tick();
    bus.confirmar_ataque_i = 1'b0;
    tick();
    led_pre = bus.ledRGB_o;
    tick();
    led_e = bus.ledRGB_o;
    held  = 1'b1;
    for (int i = 1; i < TEMPO; i++) begin
      tick();
      if (bus.ledRGB_o !== led_e) held = 1'b0;
    end
    tick();
    led_a = bus.ledRGB_o;
  endtask

  logic [1:0] led_pre, led_e, led_a, exp_led, exp_after;
  logic       held;
  bit         done;
  int         c, r, n, k;

  initial begin
    tabela[0] = '{5, 7, 2'b01, 14, 2'b00, 1'b0};
    tabela[1] = '{6, 1, 2'b11, 14, 2'b00, 1'b0};
    tabela[2] = '{5, 7, 2'b11, 14, 2'b00, 1'b0};
    tabela[3] = '{0, 3, 2'b11, 14, 2'b00, 1'b0};
    tabela[4] = '{2, 0, 2'b11, 14, 2'b00, 1'b0};
    tabela[5] = '{1, 7, 2'b01, 13, 2'b00, 1'b0};
    tabela[6] = '{2, 3, 2'b10, 12, 2'b00, 1'b0};
    tabela[7] = '{2, 3, 2'b11, 12, 2'b00, 1'b0};
    tabela[8] = '{7, 7, 2'b11, 12, 2'b00, 1'b0};
    tabela[9] = '{4, 5, 2'b10, 11, 2'b10, 1'b1};

    reset                  = 1'b1;
    bus.ligado_i           = 1'b1;
    bus.modo_i             = 1'b0;
    bus.salvar_jogo_i      = 1'b0;
    bus.confirmar_ataque_i = 1'b0;
    bus.ataque_colunas_i   = 3'd0;
    bus.ataque_linhas_i    = 3'd0;
    drive_board('1);
    tick();
    tick();
    check("reset_saida", saida1, {35{1'b1}});
    check("reset_led", bus.ledRGB_o, 2'b00);
    check("reset_tent", bus.tentativas_restantes_o, 15);
    check("reset_fim", bus.fim_jogo_o, 1'b0);

    // Positioning display follows the switches one cycle late.
    reset = 1'b0;
    bus.coluna1_posicionamento_i = 7'b1111110;
    tick();
    tick();
    check("pos_col1", bus.coluna1_saida_o, 7'b1111110);
    check("pos_led", bus.ledRGB_o, 2'b00);
    check("pos_tent", bus.tentativas_restantes_o, 15);
    bus.coluna3_posicionamento_i = 7'b0101010;
    check("pos_col3_before", bus.coluna3_saida_o, 7'b1111111);
    tick();
    check("pos_col3_lag1", bus.coluna3_saida_o, 7'b0101010);

    // Save ship at (1,1); an empty save afterwards is rejected and the fleet kept.
    drive_board({{28{1'b1}}, 7'b1111110});
    tick();
    save_board();
    drive_board('1);
    tick();
    save_board();
    bus.modo_i = 1'b1;
    tick();
    tick();
    check("atk_saida_empty", saida1, {35{1'b1}});
    do_attack(1, 1, led_pre, led_e, held, led_a);
    check("win_led_pre", led_pre, 2'b00);
    check("win_led", led_e, 2'b10);
    check("win_held", held, 1'b1);
    check("win_led_after", led_a, 2'b10);
    check("win_fim", bus.fim_jogo_o, 1'b1);
    check("win_col1", bus.coluna1_saida_o, 7'b1111110);
    check("win_tent", bus.tentativas_restantes_o, 14);
    do_attack(2, 2, led_pre, led_e, held, led_a);
    check("win_sticky_led", led_a, 2'b10);
    check("win_sticky_tent", bus.tentativas_restantes_o, 14);
    check("win_sticky_fim", bus.fim_jogo_o, 1'b1);

    // Table-driven game: ships (2,3) and (4,5).
    bus.modo_i = 1'b0;
    tick();
    tick();
    check("back_fim", bus.fim_jogo_o, 1'b0);
    check("back_tent", bus.tentativas_restantes_o, 15);
    model_clear(15);
    model_ship(2, 3);
    model_ship(4, 5);
    drive_board(exp_map(1'b1));
    tick();
    save_board();
    bus.modo_i = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      do_attack(tabela[i].col, tabela[i].row, led_pre, led_e, held, led_a);
      check($sformatf("tab%0d_led_pre", i), led_pre, 2'b00);
      check($sformatf("tab%0d_led", i), led_e, tabela[i].led);
      check($sformatf("tab%0d_held", i), held, 1'b1);
      check($sformatf("tab%0d_tent", i), bus.tentativas_restantes_o, tabela[i].tent);
      check($sformatf("tab%0d_led_after", i), led_a, tabela[i].led_after);
      check($sformatf("tab%0d_fim", i), bus.fim_jogo_o, tabela[i].fim);
    end
    // The two-attempt instance lost after the two misses in the table.
    check("def_fim", bus2.fim_jogo_o, 1'b1);
    check("def_led", bus2.ledRGB_o, 2'b01);
    check("def_tent", bus2.tentativas_restantes_o, 0);
    check("def_saida", saida2, exp_map(1'b1));

    // Confirm held through the hold is not queued; then power off mid-hold.
    bus.modo_i = 1'b0;
    tick();
    tick();
    model_clear(15);
    model_ship(2, 3);
    drive_board(exp_map(1'b1));
    tick();
    save_board();
    bus.modo_i = 1'b1;
    tick();
    tick();
    bus.ataque_colunas_i   = 3'd3;
    bus.ataque_linhas_i    = 3'd3;
    bus.confirmar_ataque_i = 1'b1;
    repeat (3) tick();
    check("drop_led", bus.ledRGB_o, 2'b01);
    repeat (TEMPO + 3) tick();
    check("drop_led_after", bus.ledRGB_o, 2'b00);
    check("drop_tent", bus.tentativas_restantes_o, 14);
    bus.confirmar_ataque_i = 1'b0;
    tick();
    bus.ataque_linhas_i    = 3'd4;
    bus.confirmar_ataque_i = 1'b1;
    tick();
    bus.confirmar_ataque_i = 1'b0;
    tick();
    tick();
    check("off_led_before", bus.ledRGB_o, 2'b01);
    bus.ligado_i = 1'b0;
    tick();
    check("off_saida", saida1, {35{1'b1}});
    check("off_led", bus.ledRGB_o, 2'b00);
    check("off_tent", bus.tentativas_restantes_o, 15);
    bus.ligado_i = 1'b1;
    tick();
    tick();
    do_attack(2, 3, led_pre, led_e, held, led_a);
    check("unsaved_led", led_e, 2'b00);
    check("unsaved_led_after", led_a, 2'b00);
    check("unsaved_tent", bus.tentativas_restantes_o, 15);
    check("unsaved_saida", saida1, {35{1'b1}});

    // Random games against the model.
    for (int g = 0; g < 20; g++) begin
      bus.modo_i = 1'b0;
      tick();
      tick();
      model_clear(15);
      k = $urandom_range(1, 4);
      for (int s = 0; s < k; s++) model_ship($urandom_range(1, 5), $urandom_range(1, 7));
      drive_board(exp_map(1'b1));
      tick();
      check($sformatf("g%0d_display", g), saida1, exp_map(1'b1));
      save_board();
      bus.modo_i = 1'b1;
      tick();
      tick();
      done = 1'b0;
      n    = 0;
      while (!done && n < 40) begin
        if ($urandom_range(0, 1) == 1) begin
          k = ships[$urandom_range(0, ships.size() - 1)];
          c = k / 8;
          r = k % 8;
        end else begin
          c = $urandom_range(0, 7);
          r = $urandom_range(0, 7);
        end
        exp_led = model_attack(c, r);
        if (m_hits == m_total)  begin exp_after = 2'b10; done = 1'b1; end
        else if (m_tent == 0)   begin exp_after = 2'b01; done = 1'b1; end
        else                          exp_after = 2'b00;
        do_attack(c, r, led_pre, led_e, held, led_a);
        check($sformatf("g%0d_a%0d_led(%0d,%0d)", g, n, c, r), led_e, exp_led);
        check($sformatf("g%0d_a%0d_held", g, n), held, 1'b1);
        check($sformatf("g%0d_a%0d_tent", g, n), bus.tentativas_restantes_o, m_tent);
        check($sformatf("g%0d_a%0d_after", g, n), led_a, exp_after);
        check($sformatf("g%0d_a%0d_fim", g, n), bus.fim_jogo_o, done);
        check($sformatf("g%0d_a%0d_saida", g, n), saida1,
              exp_map(exp_after == 2'b01));
        n++;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
